// File: rtl/load_store_unit.sv
// Word-port load/store unit: byte/half/word accesses, read-modify-write sub-word stores.
// Optional LSU_STATS_EN adds load_count/store_count completion counters.
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] mem_out
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]           load_count,
    output logic [31:0]           store_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  req_err;
    logic [4:0]            sh;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign accept = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Byte lane shift; a legal half has off[0]=0 so the same shift selects its pair.
    assign sh      = {off_q, 3'b000};
    assign ld_byte = mem_out[sh +: 8];
    assign ld_half = mem_out[sh +: 16];

    always_comb begin
        ld_data = mem_out;
        unique case (size_q)
            2'b00:   ld_data = {{(DATA_WIDTH-8){~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{(DATA_WIDTH-16){~uns_q & ld_half[15]}}, ld_half};
            default: ld_data = mem_out;
        endcase
    end

    always_comb begin
        lane_mask = '1;
        unique case (size_q)
            2'b00:   lane_mask = DATA_WIDTH'(32'h0000_00FF) << sh;
            2'b01:   lane_mask = DATA_WIDTH'(32'h0000_FFFF) << sh;
            default: lane_mask = '1;
        endcase
        merged = (word_q & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_write && req_size == 2'b10)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    state_d = wr_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                off_q   <= req_addr[1:0];
                idx_q   <= req_addr[ADDR_WIDTH+1:2];
                wdata_q <= req_wdata;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            if (state_q == READ) begin
                word_q <= mem_out;
                if (!wr_q)
                    rdata_q <= ld_data;
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign resp_err   = (state_q == RESP) && err_q;
    assign mem_write  = (state_q == WRITE);
    assign mem_addr   = idx_q;
    assign mem_in     = (state_q == WRITE) ?
                        ((size_q == 2'b10) ? wdata_q : merged) : '0;

`ifdef LSU_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (state_q == RESP && !err_q) begin
            if (wr_q)
                store_count <= store_count + 32'd1;
            else
                load_count <= load_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array memory model.
// Directed cases cover the store/load, RMW, extension, error, backpressure and reset scenarios.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
`ifdef LSU_STATS_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
    int          exp_loads = 0;
    int          exp_stores = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:1023];
    logic [7:0]  ref_mem [0:4095];

    always #5 clk = ~clk;

    assign mem_out = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_in;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_out(mem_out)
`ifdef LSU_STATS_EN
        , .load_count(load_count), .store_count(store_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_bad(input logic [1:0] size, input logic [31:0] a);
        return size == 2'd3 || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] a);
        int n = 1 << size;
        int base = int'(a & 32'hFFF);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = v + (32'(ref_mem[base+i]) << (8*i));
        if (!uns && size == 2'd0 && v[7])  v = v - 32'h100;
        if (!uns && size == 2'd1 && v[15]) v = v - 32'h10000;
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
        int n = 1 << size;
        int base = int'(a & 32'hFFF);
        for (int i = 0; i < n; i++) ref_mem[base+i] = 8'(d >> (8*i));
    endtask

    task automatic run_op(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic [31:0] wd);
        logic        bad = is_bad(size, a);
        int          exp_lat;
        int          exp_nwr;
        logic [31:0] exp_rd = 0;
        int          lat;
        int          nwr = 0;
        int          w = 0;
        logic [9:0]  wa = 0;
        wd = 0;
        exp_lat = bad ? 1 : (!wr ? 2 : (size == 2'd2 ? 2 : 3));
        exp_nwr = (!bad && wr) ? 1 : 0;
        if (!bad && !wr) exp_rd = ref_load(size, uns, a);
        if (!bad && wr) ref_store(size, a, d);
`ifdef LSU_STATS_EN
        if (!bad && wr) exp_stores++;
        if (!bad && !wr) exp_loads++;
`endif
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = size;
        req_unsigned = uns; req_addr = a; req_wdata = d;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        check("ready_before_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            if (mem_write) begin nwr++; wa = mem_addr; wd = mem_in; end
            @(negedge clk);
            lat++;
        end
        check("resp_seen", 32'(resp_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(resp_err), 32'(bad));
        check("resp_rdata", resp_rdata, exp_rd);
        check("write_count", 32'(nwr), 32'(exp_nwr));
        if (exp_nwr == 1) begin
            check("write_addr", 32'(wa), 32'(a[11:2]));
            check("write_data", wd, ref_word(int'(a[11:2])));
        end
        rdata = resp_rdata;
        @(negedge clk);
        check("resp_pulse_end", 32'(resp_valid), 32'd0);
        check("rdata_idle_zero", resp_rdata, 32'd0);
        check("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic [31:0] wd;
    int          seen_wr;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v = $urandom;
            mem[i] = v;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(v >> (8*b));
        end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_in", mem_in, 32'd0);

        run_op(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, wd);
        check("word_store_data", wd, 32'hDEADBEEF);
        run_op(0, 2'd2, 0, 32'h10, 0, rd, wd);
        check("word_load", rd, 32'hDEADBEEF);

        run_op(1, 2'd2, 0, 32'h10, 32'h11223344, rd, wd);
        run_op(1, 2'd0, 0, 32'h12, 32'h000000AA, rd, wd);
        check("byte_rmw_data", wd, 32'h11AA3344);

        run_op(1, 2'd2, 0, 32'h10, 32'h80FF7F01, rd, wd);
        run_op(0, 2'd0, 0, 32'h11, 0, rd, wd);
        check("lb_0x11", rd, 32'h0000007F);
        run_op(0, 2'd0, 0, 32'h12, 0, rd, wd);
        check("lb_0x12", rd, 32'hFFFFFFFF);
        run_op(0, 2'd1, 1, 32'h12, 0, rd, wd);
        check("lhu_0x12", rd, 32'h000080FF);
        run_op(0, 2'd1, 0, 32'h12, 0, rd, wd);
        check("lh_0x12", rd, 32'hFFFF80FF);

        run_op(0, 2'd2, 0, 32'h13, 0, rd, wd);
        run_op(1, 2'd1, 0, 32'h11, 32'h1234, rd, wd);
        run_op(1, 2'd3, 0, 32'h10, 32'h5555, rd, wd);

        // Held request: busy for READ and RESP, accepted again only once idle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h10;
        @(negedge clk);
        check("bp_ready_read", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_ready_resp", 32'(req_ready), 32'd0);
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        check("bp_rdata", resp_rdata, ref_load(2'd2, 0, 32'h10));
        @(negedge clk);
        check("bp_ready_idle", 32'(req_ready), 32'd1);
        check("bp_no_resp", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_no_second", 32'(req_ready), 32'd1);

        // Reset during the READ cycle of a byte store.
        seen_wr = 0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h21;
        req_wdata = 32'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_write) seen_wr++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_resp", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (mem_write || resp_valid) seen_wr++;
            @(negedge clk);
        end
        check("mid_rst_no_write", 32'(seen_wr), 32'd0);
        run_op(0, 2'd2, 0, 32'h20, 0, rd, wd);
        check("mid_rst_mem_kept", mem[8], ref_word(8));

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 47));
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom, rd, wd);
        end

        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_word(i));

`ifdef LSU_STATS_EN
        check("load_count", load_count, 32'(exp_loads));
        check("store_count", store_count, 32'(exp_stores));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
